// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq -- multi-cycle signed/unsigned WIDTH x WIDTH multiplier.
//
// The multiplier operand is consumed one 4-bit digit per cycle. Each cycle a
// WIDTH x 4 partial product is formed from WIDTH/4 4x4 Vedic cells and an
// adder chain, shifted into place and added into a 2*WIDTH-bit accumulator.
// Signed operands are handled by multiplying magnitudes and negating the
// final sum, so the array only ever sees unsigned data.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (aborts any operation)
//   in_valid   a, b, is_signed are valid
//   in_ready   block is idle and will accept an operation
//   a          multiplicand (WIDTH bits)
//   b          multiplier (WIDTH bits)
//   is_signed  1: two's complement operands, 0: unsigned
//   out_valid  p holds a finished product
//   out_ready  consumer accepts p
//   p          product (2*WIDTH bits), registered

// 4x4 Vedic (Urdhva-Tiryakbhyam) multiplier built from four 2x2 cells.
module vedic4x4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] prod
);
   // 2x2 cell: vertical and crosswise products combined with two half adders.
   function automatic logic [3:0] v2x2(input logic [1:0] u, input logic [1:0] v);
      logic s0, s1, s2, s3, c1, t, w, hh;
      s0 = u[0] & v[0];
      t  = u[1] & v[0];
      w  = u[0] & v[1];
      s1 = t ^ w;
      c1 = t & w;
      hh = u[1] & v[1];
      s2 = hh ^ c1;
      s3 = hh & c1;
      return {s3, s2, s1, s0};
   endfunction

   logic [3:0] q_ll, q_hl, q_lh, q_hh;

   assign q_ll = v2x2(x[1:0], y[1:0]);
   assign q_hl = v2x2(x[3:2], y[1:0]);
   assign q_lh = v2x2(x[1:0], y[3:2]);
   assign q_hh = v2x2(x[3:2], y[3:2]);

   // Crosswise terms land at weight 4, the high vertical term at weight 16.
   assign prod = {4'b0000, q_ll}
               + {2'b00, q_hl, 2'b00}
               + {2'b00, q_lh, 2'b00}
               + {q_hh, 4'b0000};
endmodule

module vedic_mult_seq #(
   parameter int WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state_reg;
   logic [CW-1:0]        count_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [2*WIDTH-1:0]   p_reg;
   logic [WIDTH-1:0]     ma_reg;
   logic [WIDTH-1:0]     mb_reg;
   logic                 neg_reg;

   // Magnitudes: the most negative value maps to 2^(WIDTH-1), which still
   // fits in WIDTH unsigned bits.
   logic [WIDTH-1:0] a_mag, b_mag;
   assign a_mag = (is_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
   assign b_mag = (is_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

   // Current multiplier digit selected by the iteration counter.
   logic [3:0] digit;
   assign digit = mb_reg[{count_reg, 2'b00} +: 4];

   // WIDTH x 4 partial product: one Vedic cell per multiplicand digit,
   // summed by a ripple of shifted adds.
   logic [7:0]       cell_prod [N];
   logic [WIDTH+3:0] pp_chain  [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_cell
         vedic4x4 u_cell (
            .x    (ma_reg[4*gi +: 4]),
            .y    (digit),
            .prod (cell_prod[gi])
         );
         if (gi == 0) begin : g_first
            assign pp_chain[gi] = (WIDTH+4)'(cell_prod[gi]);
         end else begin : g_rest
            assign pp_chain[gi] = pp_chain[gi-1]
                                + ((WIDTH+4)'(cell_prod[gi]) << (4*gi));
         end
      end
   endgenerate

   logic [2*WIDTH-1:0] pp_shifted;
   logic [2*WIDTH-1:0] acc_next;
   assign pp_shifted = (2*WIDTH)'(pp_chain[N-1]) << {count_reg, 2'b00};
   assign acc_next   = acc_reg + pp_shifted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         acc_reg   <= '0;
         p_reg     <= '0;
         ma_reg    <= '0;
         mb_reg    <= '0;
         neg_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  ma_reg    <= a_mag;
                  mb_reg    <= b_mag;
                  neg_reg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc_reg   <= '0;
                  count_reg <= '0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               acc_reg   <= acc_next;
               count_reg <= count_reg + 1'b1;
               if (count_reg == CW'(N-1)) begin
                  // Final digit: fold the last partial product straight into p.
                  p_reg     <= neg_reg ? ((2*WIDTH)'(0) - acc_next) : acc_next;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign p         = p_reg;
endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq (WIDTH=24): directed reset, corner,
// backpressure and abort cases, then randomized operations compared against
// an arithmetic reference product, with latency checked on every operation.
module tb_vedic_mult_seq;
   localparam int W = 24;
   localparam int N = W / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   p;

   int n_checks = 0;
   int n_fail   = 0;

   vedic_mult_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample point: 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Exact product reduced mod 2^(2W): extend each operand to 2W bits by its
   // signedness and multiply.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
      logic [2*W-1:0] ex, ey;
      ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      return ex * ey;
   endfunction

   // One full transaction. pre: idle cycles before the request; stall: DONE
   // cycles with out_ready low, during which a competing request is driven.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input int pre, input int stall);
      logic [2*W-1:0] exp_p, held;
      int lat;
      logic saw_ready;
      exp_p = ref_mul(av, bv, sv);
      in_valid = 1'b0;
      repeat (pre) tick();
      a = av; b = bv; is_signed = sv; in_valid = 1'b1;
      out_ready = (stall == 0);
      lat = 0;
      while (!in_ready && lat < 50) begin
         tick();
         lat++;
      end
      check("accept_ready", in_ready, 1);
      tick(); // accept edge
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
      lat = 0;
      saw_ready = 1'b0;
      while (!out_valid && lat < 4*N+10) begin
         saw_ready |= in_ready;
         tick();
         lat++;
      end
      check("latency", lat, N);
      check("busy_in_ready", saw_ready, 0);
      check("product", p, exp_p);
      $display("op a=0x%06h b=0x%06h s=%0d p=0x%012h exp=0x%012h lat=%0d",
               av, bv, sv, p, exp_p, lat);
      held = p;
      repeat (stall) begin
         in_valid = 1'b1;
         a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
         tick();
         check("hold", {out_valid, in_ready, p}, {1'b1, 1'b0, held});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (stall > 0) tick();
      tick();
      check("release", {out_valid, in_ready, p}, {1'b0, 1'b1, held});
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      int sel;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;

      // Reset held 3 cycles, one with a request present.
      tick();
      in_valid = 1'b1; a = W'(5); b = W'(5);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("reset", {out_valid, in_ready, p}, {1'b0, 1'b1, 48'h0});
      tick(); tick();
      check("reset_idle", {out_valid, in_ready, p}, {1'b0, 1'b1, 48'h0});

      // Directed corners.
      do_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 0);
      check("max_unsigned", p, 48'hFFFFFE000001);
      do_op(24'h800000, 24'hFFFFFF, 1'b1, 1, 0);
      check("minneg_x_m1", p, 48'h000000800000);
      do_op(24'h800000, 24'h800000, 1'b1, 0, 0);
      check("minneg_sq", p, 48'h400000000000);
      do_op(24'h000003, 24'hFFFFFB, 1'b1, 0, 0);
      check("3_x_m5", p, 48'hFFFFFFFFFFF1);

      // Backpressure: 10 stalled DONE cycles with competing requests.
      do_op(24'h123456, 24'h0ABCDE, 1'b0, 0, 10);

      // Abort on the third CALC iteration.
      in_valid = 1'b1; a = 24'h00FFFF; b = 24'h00FFFF; is_signed = 1'b0;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort", {out_valid, in_ready, p}, {1'b0, 1'b1, 48'h0});
      do_op(24'd7, 24'd9, 1'b0, 0, 0);
      check("after_abort", p, 48'd63);

      // Randomized regression.
      for (int i = 0; i < 2500; i++) begin
         sel = $urandom_range(0, 7);
         ra = W'($urandom);
         rb = W'($urandom);
         if (sel == 0) ra = 24'h800000;
         if (sel == 1) rb = 24'hFFFFFF;
         if (sel == 2) ra = '0;
         do_op(ra, rb, 1'($urandom), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vedic_mult_seq.md
# vedic_mult_seq

Parametrised, multi-cycle successor to the team's fixed 4x4 Vedic multiplier. It multiplies two WIDTH-bit operands, signed or unsigned, selected per transaction, and produces a 2*WIDTH-bit product. Each cycle it consumes one 4-bit digit of the multiplier using a WIDTH x 4 Vedic partial-product array, so the block's area scales linearly with WIDTH instead of quadratically. It sits behind a valid/ready handshake and feeds the integer MUL path and the FPU mantissa multiplier (WIDTH=24).

## Interface
Parameters:
- WIDTH, default 24: operand width. Must be a multiple of 4 and at least 4.
- N (localparam) = WIDTH/4: number of digit iterations.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 means a and b are two's complement; 0 means unsigned.
- out_valid  output  1  p holds a finished product.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  product.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **Reset** forces:
  - state to IDLE, count to 0 and the accumulator to 0;
  - p to 0, out_valid to 0 and in_ready to 1.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready, the block latches:
    - ma = |a| and mb = |b|, with the magnitude taken only if is_signed=1;
    - neg = is_signed & (a[MSB] ^ b[MSB]).
  - It then clears acc and count and goes to CALC.
  - Magnitudes are WIDTH-bit unsigned. The case -2^(WIDTH-1) gives 2^(WIDTH-1), which fits without overflow.
- **CALC**
  - in_ready = 0 and out_valid = 0.
  - Each edge performs acc <= acc + ((ma * mb[4*count+3:4*count]) << 4*count), then count <= count+1.
  - The partial product ma * digit is WIDTH+4 bits, built from WIDTH/4 4x4 Vedic cells plus an adder chain.
  - acc is 2*WIDTH bits. The sum never overflows.
  - On the edge where count == N-1:
    - p <= neg ? -(acc + last_partial) : (acc + last_partial), in 2*WIDTH-bit two's complement;
    - state goes to DONE.
- **DONE**
  - out_valid = 1 and in_ready = 0.
  - p is held stable until the handshake completes.
  - On out_valid && out_ready the state goes to IDLE. out_valid falls on that edge, and p keeps its value until the next product is written.
- An unsigned result equals a*b mod 2^(2W), which is exact. A signed result equals the exact two's-complement product.
- Inputs a, b and is_signed are sampled only on the accept edge. Changes at other times have no effect.
- in_valid while the block is busy is ignored. The producer must hold its request until in_ready=1.
- Reset in any state, including mid-CALC or in DONE with out_ready low, aborts the operation immediately. No product is emitted.

## Timing
- The accept edge is E0, the edge where in_valid && in_ready.
- Edges E0+1 through E0+N are the N CALC iterations.
- out_valid is high starting at edge E0+N, so latency is N edges. For WIDTH=24 that is 6 cycles.
- If out_ready=1 when out_valid rises, DONE lasts one cycle and in_ready is high again after edge E0+N+1.
- Back-to-back throughput is one operation per N+2 cycles. There is no overlap between operations.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.
- p is a register, and no output depends combinationally on any input.
- The critical path is one WIDTH x 4 partial product plus one 2*WIDTH-bit add. It must close at the core clock for WIDTH=32.

## Test plan
- **Reset:** hold rst for 3 cycles, including one cycle with in_valid=1, then release. Required: p=0, out_valid=0, in_ready=1, and no operation starts.
- **Unsigned directed, WIDTH=24:** a=0xFFFFFF, b=0xFFFFFF, is_signed=0. Required: p=0xFFFFFE000001, out_valid rises exactly 6 edges after accept, and in_ready is 0 throughout.
- **Signed corners, WIDTH=24, is_signed=1:**
  - a=0x800000 (-8388608), b=0xFFFFFF (-1) -> p=0x000000800000.
  - a=0x800000, b=0x800000 -> p=0x400000000000.
  - a=3, b=0xFFFFFB (-5) -> p=0xFFFFFFFFFFF1 (-15).
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid. Required: p and out_valid stay stable and in_ready=0; a new in_valid with different operands is ignored. Raising out_ready returns the block to IDLE on the next edge.
- **Reset mid-operation:** assert rst at iteration 3 of 6. Required: the next cycle shows IDLE, p=0 and out_valid=0. A following operation 7x9 unsigned gives p=63.
- **Random regression:** 10k random a, b and is_signed values at WIDTH=4, 8, 24 and 32, with random in_valid and out_ready stalls. Check each result against a behavioural reference product and check the latency is exactly N edges.
